// File: rtl/aes_pkg.sv
// Shared AES types, the FIPS-197 forward S-box table and the SubBytes FSM state type.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [0:127] state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sb_state_e;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box; shared by SubBytes and key expansion.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t sbox_in,
    output byte_t sbox_out
);

    assign sbox_out = SBOX[sbox_in];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES bytes substituted per cycle through shared S-boxes,
// result held on a valid/ready output until the downstream ShiftRows stage takes it.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:127]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:127]  out_data,
    output logic          busy
);

    localparam int unsigned N  = 16 / LANES;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t      data_q, data_d;

    byte_t       sbox_in  [LANES];
    byte_t       sbox_out [LANES];
    int unsigned byte_base;

    assign byte_base = 32'(cnt_q) * LANES;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox u_sbox (
            .sbox_in  (sbox_in[l]),
            .sbox_out (sbox_out[l])
        );
    end

    // Lane l always serves byte cnt*LANES + l of the current state.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            sbox_in[l] = data_q[7'(8 * (byte_base + l)) +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    data_d[7'(8 * (byte_base + l)) +: 8] = sbox_out[l];
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter: driver queues expected states, a negedge monitor
// checks latency and data at each output; extra instances cover the other LANES values.
module tb_sub_bytes_iter;
    import aes_pkg::*;

    localparam state_t APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam state_t APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam state_t ZERO_IN  = 128'h0;
    localparam state_t ZERO_OUT = 128'h63636363636363636363636363636363;
    localparam state_t MIX_IN   = 128'h53ff0100000000000000000000000000;
    localparam state_t MIX_OUT  = 128'hed167c63636363636363636363636363;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst, in_valid, out_ready;
    state_t in_data;
    logic   in_ready, out_valid, busy;
    state_t out_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        state_t data;
        int     acc;
    } exp_t;
    exp_t exp_q[$];

    sub_bytes_iter #(.LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_state(input string name, input state_t act, input state_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: latency on out_valid rise, data on each output handshake.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) check_int("unexpected_out_valid", 1, 0);
                else check_int("latency", cyc - exp_q[0].acc, 4);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_int("unexpected_handshake", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_state("out_data", out_data, e.data);
                end
            end
        end
        prev_ov = out_valid;
    end

    // Called at a negedge; leaves in_valid high so callers can stream back-to-back.
    task automatic send(input state_t d, input state_t e, output int acc);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        acc      = -1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_int("accept_timeout", 0, 1);
        end else begin
            acc = cyc + 1;
            exp_q.push_back('{e, acc});
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("wait_out_valid", int'(out_valid), 1);
    endtask

    // Other LANES values, all fed the same App. B vector at the same cycle.
    localparam int SW_LANES [4] = '{1, 2, 8, 16};
    localparam int SW_LAT   [4] = '{16, 8, 2, 1};
    logic   sw_rst, sw_in_valid;
    state_t sw_in_data;
    int     sw_acc  = 0;
    int     sw_seen = 0;
    logic   sw_idle [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        logic   ir, ov, bz;
        state_t od;
        logic   prev = 1'b0;

        sub_bytes_iter #(.LANES(SW_LANES[g])) u_dut (
            .clk       (clk),
            .rst       (sw_rst),
            .in_valid  (sw_in_valid),
            .in_ready  (ir),
            .in_data   (sw_in_data),
            .out_valid (ov),
            .out_ready (1'b1),
            .out_data  (od),
            .busy      (bz)
        );

        assign sw_idle[g] = ir && !bz;

        always @(negedge clk) begin
            if (!sw_rst && ov && !prev) begin
                check_int($sformatf("sweep_latency_lanes%0d", SW_LANES[g]), cyc - sw_acc, SW_LAT[g]);
                check_state($sformatf("sweep_data_lanes%0d", SW_LANES[g]), od, APPB_OUT);
                sw_seen++;
            end
            prev = ov;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a1, a2, a3, n;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        sw_rst      = 1'b1;
        sw_in_valid = 1'b0;
        sw_in_data  = '0;
        repeat (3) @(negedge clk);

        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check_state("reset_out_data", out_data, '0);
        rst = 1'b0;
        @(negedge clk);

        // Single-byte S-box values and the App. B round-1 vector.
        out_ready = 1'b1;
        send(ZERO_IN, ZERO_OUT, a1);
        in_valid = 1'b0;
        drain();
        send(MIX_IN, MIX_OUT, a1);
        in_valid = 1'b0;
        drain();
        send(APPB_IN, APPB_OUT, a1);
        in_valid = 1'b0;
        drain();

        // Output backpressure: result held for 10 cycles.
        out_ready = 1'b0;
        send(APPB_IN, APPB_OUT, a1);
        in_valid = 1'b0;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_int("hold_out_valid", int'(out_valid), 1);
            check_int("hold_in_ready", int'(in_ready), 0);
            check_state("hold_out_data", out_data, APPB_OUT);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_int("release_in_ready", int'(in_ready), 1);
        check_int("release_out_valid", int'(out_valid), 0);
        drain();

        // Back-to-back stream with in_valid held high.
        send(ZERO_IN, ZERO_OUT, a1);
        send(APPB_IN, APPB_OUT, a2);
        send(MIX_IN, MIX_OUT, a3);
        in_valid = 1'b0;
        check_int("stream_spacing_1_2", a2 - a1, 6);
        check_int("stream_spacing_2_3", a3 - a2, 6);
        drain();

        // Reset at RUN cycle 2 discards the in-flight state.
        send(APPB_IN, APPB_OUT, a1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_int("midrun_rst_out_valid", int'(out_valid), 0);
        check_int("midrun_rst_in_ready", int'(in_ready), 1);
        check_int("midrun_rst_busy", int'(busy), 0);
        check_state("midrun_rst_out_data", out_data, '0);
        in_valid = 1'b1;
        in_data  = MIX_IN;
        @(negedge clk);
        check_int("rst_with_in_valid_busy", int'(busy), 0);
        check_state("rst_with_in_valid_out_data", out_data, '0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        send(APPB_IN, APPB_OUT, a1);
        in_valid = 1'b0;
        drain();

        // Parameter sweep.
        sw_rst = 1'b0;
        @(negedge clk);
        check_int("sweep_all_idle", int'(sw_idle[0] && sw_idle[1] && sw_idle[2] && sw_idle[3]), 1);
        sw_in_valid = 1'b1;
        sw_in_data  = APPB_IN;
        sw_acc      = cyc + 1;
        @(negedge clk);
        sw_in_valid = 1'b0;
        n = 0;
        while (sw_seen < 4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_int("sweep_outputs_seen", sw_seen, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
Iterative AES SubBytes stage that sits directly upstream of the ShiftRows stage in the encryption round datapath. It accepts one 128-bit state per valid/ready handshake. It substitutes LANES bytes per cycle through shared S-box instances and presents the substituted state, held stable, on a valid/ready output. This trades latency for S-box area on the Zed board build.

Parameters:
LANES, 4, number of S-box instances / bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream state available
in_ready  output  1  block can accept a state
in_data  input  [0:127]  input state; byte k = in_data[8k+:8]; column c = bytes 4c..4c+3
out_valid  output  1  substituted state available
out_ready  input  1  downstream (ShiftRows side) accepts state
out_data  output  [0:127]  substituted state, same byte ordering as in_data
busy  output  1  high in RUN or DONE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). No asynchronous logic.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - out_data = 0 and byte counter = 0.
- Let N = 16/LANES.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - If in_valid is high at a rising edge: latch in_data into the state register, counter := 0, go to RUN.
  - If in_valid is low: stay in IDLE.
- RUN:
  - in_ready = 0.
  - Each edge replaces bytes cnt*LANES .. cnt*LANES+LANES-1 of the state register with sbox(byte); other bytes are unchanged.
  - cnt increments each edge.
  - On the edge where cnt = N-1: go to DONE, counter := 0.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - out_data is the state register and is held stable until handshake.
  - If out_ready is high at an edge: go to IDLE.
  - out_valid must not drop without a handshake.
- Latency: input handshake at edge E0. Substitution occurs on edges E1..EN. out_valid is high from just after EN. With LANES=4, out_valid asserts 4 cycles after acceptance.
- Throughput: one state per N+2 cycles, because in_ready is high only in IDLE. No overlap between output drain and the next acceptance.
- out_data is driven directly from the state register and is visible during RUN. Consumers must qualify it with out_valid only.
- Boundary conditions:
  - in_valid high outside IDLE: ignored; the upstream holds data per the handshake rules.
  - out_ready high outside DONE: ignored.
  - rst during RUN or DONE: the in-flight state is discarded. All outputs take their reset values on the next edge, and no partial state is ever presented.
  - rst and in_valid in the same cycle: rst wins; nothing is accepted.
  - LANES = 16: N = 1, so RUN lasts exactly one cycle.
  - Counter width = max(1, clog2(N)). Wrap to 0 is explicit on RUN→DONE.
- S-box: pure combinational FIPS-197 forward S-box lookup. No registers inside it.

Decomposition:
- Shared package aes_pkg holds:
  - typedef byte_t (logic [7:0]) and state_t (logic [0:127]);
  - the 256-entry SBOX constant array;
  - the FSM enum type sb_state_e (IDLE, RUN, DONE).
- The FSM enum may instead stay local if no other block uses it.
- One sub-module, aes_sbox (byte in, byte out, combinational lookup into aes_pkg::SBOX). It is instantiated LANES times via generate. The same sub-module is reused later by key expansion.

Test Plan:
- Single-byte S-box check, LANES=4: in_data bytes all 0x00 → out_data all 0x63. Bytes 0x53/0xFF/0x01 in positions 0/1/2 → 0xED/0x16/0x7C in those positions.
- FIPS-197 App. B round-1 vector: in_data 193de3bea0f4e22b9ac68d2ae9f84808 → out_data d42711aee0bf98f1b8b45de51e415230. out_valid rises exactly 4 cycles after the input handshake.
- Output backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_data stays constant, in_ready stays 0. Raise out_ready → IDLE next cycle, in_ready=1.
- Back-to-back stream: 3 states with in_valid held high, out_ready=1 → each output is correct and in order, with a 6-cycle spacing between acceptances (LANES=4).
- Reset mid-RUN: assert rst at RUN cycle 2 → next edge gives out_valid=0, in_ready=1, out_data=0, busy=0. A fresh state after reset produces a correct result.
- Parameter sweep: rerun the App. B vector with LANES=1, 2, 8, 16 → same out_data, with latency of 16, 8, 2 and 1 cycles respectively.
